// File: rtl/rng_pkg.sv
// Shared types and default parameters for the RNG byte collector.
// Holds the output-stage state encoding used by the collector FSM.
package rng_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned RCT_CUTOFF_DEF = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rng_rct_check.sv
// Repetition-count health test, compiled only when RNG_REPETITION_TEST_EN is defined.
// Latency: o_fail rises on the edge that accepts the CUTOFF-th identical bit; sticky until i_rst.
`ifdef RNG_REPETITION_TEST_EN
module rng_rct_check
    import rng_pkg::*;
#(
    parameter int unsigned CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bit,
    input  logic i_bit_vld,
    output logic o_fail
);

    logic       r_last;
    logic [7:0] r_count;
    logic       r_fail;
    logic [7:0] w_count_next;

    // A run restarts at 1 on the first bit after reset or on any change of value.
    always_comb begin
        w_count_next = r_count;
        if (i_bit_vld) begin
            if (r_count == 8'd0 || i_bit != r_last) begin
                w_count_next = 8'd1;
            end else if (r_count != 8'hFF) begin
                w_count_next = r_count + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last  <= 1'b0;
            r_count <= 8'd0;
            r_fail  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (i_bit_vld) begin
                r_last <= i_bit;
            end
            if (w_count_next >= 8'(CUTOFF)) begin
                r_fail <= 1'b1;
            end
        end
    end

    assign o_fail = r_fail;

endmodule
`endif

// File: rtl/rng_byte_collector.sv
// Packs accepted random bits MSB-first into DATA_W-bit words; word is registered 1 cycle after its last bit.
// Single-entry valid/ready output: a word completing while one is held unconsumed is dropped and flags o_overflow; RNG_REPETITION_TEST_EN adds the health test.
module rng_byte_collector
    import rng_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_random,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overflow,
    output logic              o_health_fail
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    if (DATA_W < 2 || DATA_W > 32 || RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_param_err
        $error("rng_byte_collector: DATA_W or RCT_CUTOFF out of range");
    end

    out_state_t        r_state;
    out_state_t        w_state_next;
    logic [DATA_W-2:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_overflow;

    logic              w_rst;
    logic              w_fail;
    logic              w_accept;
    logic              w_last;
    logic              w_complete;
    logic              w_load;
    logic              w_set_ovf;
    logic [DATA_W-1:0] w_word;

    assign w_rst      = i_rst | i_clear;
    assign w_accept   = i_valid & ~w_fail;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_complete = w_accept & w_last;
    // Only DATA_W-1 bits are stored; the incoming bit completes the word combinationally.
    assign w_word     = {r_shift, i_random};

`ifdef RNG_REPETITION_TEST_EN
    rng_rct_check #(
        .CUTOFF    (RCT_CUTOFF)
    ) u_rct (
        .i_clk     (i_clk),
        .i_rst     (w_rst),
        .i_bit     (i_random),
        .i_bit_vld (w_accept),
        .o_fail    (w_fail)
    );
`else
    assign w_fail = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_complete) begin
                    w_state_next = FULL;
                    w_load       = 1'b1;
                end
            end
            FULL: begin
                if (w_complete) begin
                    if (i_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end else if (i_ready) begin
                    w_state_next = EMPTY;
                end
            end
        endcase
        if (w_fail) begin
            w_state_next = EMPTY;
            w_load       = 1'b0;
            w_set_ovf    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else if (w_fail) begin
            // A failed source invalidates everything collected so far.
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= w_word[DATA_W-2:0];
                r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_load) begin
                r_data <= w_word;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data        = r_data;
    assign o_valid       = (r_state == FULL) & ~w_fail;
    assign o_overflow    = r_overflow;
    assign o_health_fail = w_fail;

endmodule

// File: tb/tb_rng_byte_collector.sv
// Directed bench for rng_byte_collector: expected words queued by stimulus, checked by a monitor on transfer.
module tb_rng_byte_collector;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          rnd = 1'b0;
    logic          vld = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] data;
    logic          ovalid;
    logic          ovf;
    logic          hf;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rng_byte_collector #(
        .DATA_W        (DW),
        .RCT_CUTOFF    (32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clear       (clr),
        .i_random      (rnd),
        .i_valid       (vld),
        .i_ready       (rdy),
        .o_data        (data),
        .o_valid       (ovalid),
        .o_overflow    (ovf),
        .o_health_fail (hf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic r);
        vld = 1'b1;
        rnd = b;
        rdy = r;
        step();
        vld = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic r);
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(w[i], r);
        end
    endtask

    task automatic idle(input logic r, input int n);
        rdy = r;
        vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b1;
        rnd = 1'b1;
        step();
        rst = 1'b0;
        vld = 1'b0;
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (ovalid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {24'd0, data}, {24'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        logic [4:0]    part;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check("rst_valid", {31'd0, ovalid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_hf", {31'd0, hf}, 32'd0);

        // Single word with consumer ready
        exp_q.push_back(8'hB2);
        send_word(8'hB2, 1'b1);
        check("t1_valid", {31'd0, ovalid}, 32'd1);
        check("t1_data", {24'd0, data}, 32'hB2);
        idle(1'b1, 1);
        check("t1_valid_drop", {31'd0, ovalid}, 32'd0);

        // Second word dropped while the first is held
        exp_q.push_back(8'hB2);
        send_word(8'hB2, 1'b0);
        check("t2_ovf_early", {31'd0, ovf}, 32'd0);
        send_word(8'h4D, 1'b0);
        check("t2_hold_data", {24'd0, data}, 32'hB2);
        check("t2_ovf", {31'd0, ovf}, 32'd1);
        check("t2_valid_hold", {31'd0, ovalid}, 32'd1);
        idle(1'b1, 1);
        check("t2_valid_after", {31'd0, ovalid}, 32'd0);

        // Transfer coincides with completion of the next word
        do_reset();
        check("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
        exp_q.push_back(8'hB2);
        send_word(8'hB2, 1'b0);
        exp_q.push_back(8'h4D);
        w = 8'h4D;
        for (int i = DW - 1; i >= 1; i--) begin
            send_bit(w[i], 1'b0);
        end
        send_bit(w[0], 1'b1);
        check("t3_valid", {31'd0, ovalid}, 32'd1);
        check("t3_data", {24'd0, data}, 32'h4D);
        check("t3_ovf", {31'd0, ovf}, 32'd0);
        idle(1'b1, 2);
        check("t3_valid_after", {31'd0, ovalid}, 32'd0);

        // Reset mid-word discards the partial word
        part = 5'b10101;
        for (int i = 4; i >= 0; i--) begin
            send_bit(part[i], 1'b1);
        end
        do_reset();
        exp_q.push_back(8'hFF);
        send_word(8'hFF, 1'b1);
        check("t4_data", {24'd0, data}, 32'hFF);
        idle(1'b1, 1);

        // Bits presented with i_valid low are ignored
        exp_q.push_back(8'h3C);
        w = 8'h3C;
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(w[i], 1'b1);
            rnd = ~w[i];
            step();
        end
        check("t5_data", {24'd0, data}, 32'h3C);
        idle(1'b1, 1);

        // Soft clear wipes held word and overflow
        send_word(8'hA5, 1'b0);
        send_word(8'h5A, 1'b0);
        check("t6_ovf", {31'd0, ovf}, 32'd1);
        check("t6_data", {24'd0, data}, 32'hA5);
        clr = 1'b1;
        vld = 1'b1;
        step();
        clr = 1'b0;
        vld = 1'b0;
        check("t6_clr_valid", {31'd0, ovalid}, 32'd0);
        check("t6_clr_data", {24'd0, data}, 32'd0);
        check("t6_clr_ovf", {31'd0, ovf}, 32'd0);

`ifdef RNG_REPETITION_TEST_EN
        // Repetition-count failure at the 32nd identical bit
        do_reset();
        for (int i = 0; i < 31; i++) begin
            send_bit(1'b1, 1'b0);
        end
        check("rct_hf_31", {31'd0, hf}, 32'd0);
        check("rct_valid_31", {31'd0, ovalid}, 32'd1);
        send_bit(1'b1, 1'b0);
        check("rct_hf_32", {31'd0, hf}, 32'd1);
        check("rct_valid_32", {31'd0, ovalid}, 32'd0);
        for (int i = 0; i < DW; i++) begin
            send_bit(i[0], 1'b1);
        end
        check("rct_blocked_valid", {31'd0, ovalid}, 32'd0);
        check("rct_blocked_hf", {31'd0, hf}, 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("rct_clr_hf", {31'd0, hf}, 32'd0);
`else
        // Long zero run is harmless without the health test
        do_reset();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(8'h00);
            send_word(8'h00, 1'b1);
            check("zero_run_hf", {31'd0, hf}, 32'd0);
        end
        idle(1'b1, 1);
`endif

        idle(1'b0, 2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_byte_collector.md
RNG_BYTE_COLLECTOR -- requirements
Module: rng_byte_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 8: number of random bits packed per output word (2..32).
REQ-002 SHALL have parameter RCT_CUTOFF, default 32: repetition-count health-test cutoff (2..255).
REQ-003 SHALL have port i_clk, input, 1: single clock for all logic; one clock, no other clock domain.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_clear, input, 1: synchronous soft clear, same effect as i_rst.
REQ-006 SHALL have port i_random, input, 1: debiased random bit from the generator.
REQ-007 SHALL have port i_valid, input, 1: i_random is valid this cycle; one bit accepted per high cycle.
REQ-008 SHALL have port i_ready, input, 1: consumer ready for o_data.
REQ-009 SHALL have port o_data, output, DATA_W: packed random word.
REQ-010 SHALL have port o_valid, output, 1: o_data holds an unconsumed word.
REQ-011 SHALL have port o_overflow, output, 1: sticky flag, at least one completed word was dropped.
REQ-012 SHALL have port o_health_fail, output, 1: sticky repetition-count failure.

Function
REQ-013 SHALL sample i_random on every rising i_clk edge where i_valid=1 and no health failure is active; bits arriving with i_valid=0 SHALL be ignored.
REQ-014 SHALL shift accepted bits into a DATA_W-bit register left-first, so the first accepted bit of a word ends up in o_data[DATA_W-1].
REQ-015 SHALL count accepted bits 0..DATA_W-1 and wrap to 0 on the cycle the DATA_W-th bit is accepted.
REQ-016 Latency: o_data/o_valid SHALL update on the edge after the DATA_W-th bit is sampled (1 cycle, registered).
REQ-017 Output FSM SHALL have states EMPTY (o_valid=0) and FULL (o_valid=1); EMPTY->FULL on word completion; FULL->EMPTY on o_valid&i_ready with no completion that cycle.
REQ-018 A transfer SHALL occur only at an edge with o_valid=1 and i_ready=1; o_data SHALL be stable while o_valid=1 and i_ready=0.
REQ-019 Transfer and word completion in the same cycle SHALL load the new word, keep o_valid=1, and not set o_overflow.
REQ-020 Word completion in FULL without a transfer SHALL discard the new word, keep the held word, and set o_overflow.
REQ-021 i_ready while EMPTY SHALL have no effect.

Reset
REQ-022 On i_rst=1 or i_clear=1 at an edge: o_data=0, o_valid=0, o_overflow=0, o_health_fail=0, bit counter=0, shift register=0, repetition counter=0, FSM=EMPTY.
REQ-023 Reset SHALL take priority over all other inputs in the same cycle, including mid-word and mid-transfer; partial words SHALL be discarded.

Configuration
REQ-024 Macro RNG_REPETITION_TEST_EN defined: repetition-count test compiled in; counts consecutive identical accepted bits (first bit = count 1); when count reaches RCT_CUTOFF, o_health_fail SHALL be set next edge.
REQ-025 With the test compiled in, o_health_fail=1 SHALL force o_valid=0, discard held and partial words, and block bit acceptance until reset/clear.
REQ-026 Macro undefined: no repetition counter logic; o_health_fail SHALL be tied to 0 and RCT_CUTOFF SHALL be unused.

Structure
REQ-027 Shared package rng_pkg SHALL hold the output FSM state typedef (EMPTY, FULL) and default constants for DATA_W and RCT_CUTOFF.
REQ-028 The repetition-count test SHALL be a sub-module rng_rct_check (inputs clk, rst, bit, bit-valid; output fail), instantiated only under RNG_REPETITION_TEST_EN.

Verification
REQ-029 Reset, then i_valid=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 and i_ready=1 -> o_valid=1 one cycle after the 8th bit, o_data=8'hB2, then o_valid=0.
REQ-030 Two words 8'hB2 then 8'h4D with i_ready=0 -> o_data stays 8'hB2, o_overflow=1 after the 16th bit; i_ready=1 -> transfer of 8'hB2, o_valid=0.
REQ-031 i_ready=1 in the exact cycle the 2nd word completes -> o_valid stays 1, o_data=8'h4D, o_overflow=0.
REQ-032 5 bits accepted, then i_rst=1 for one cycle, then 8 bits 8'hFF -> o_data=8'hFF, no residue from the partial word.
REQ-033 With RNG_REPETITION_TEST_EN, RCT_CUTOFF=32: 31 consecutive 1s -> o_health_fail=0; 32nd 1 -> o_health_fail=1, o_valid=0, further i_valid ignored until i_clear.
REQ-034 Without the macro: 64 consecutive 0s -> eight words 8'h00 delivered, o_health_fail=0 throughout.
